// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Holds the memory op encodings, the bus FSM state encoding, the byte-enable
// constants and small op-decoding helpers used by the top and the lane logic.
package mem_access_unit_pkg;

  // Memory op encodings presented by the execute stage
  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_SB  = 4'd4,
    MEM_SH  = 4'd5,
    MEM_SW  = 4'd6
  } mem_op_e;

  // Bus handshake FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } bus_state_e;

  localparam logic [3:0] MEM_BE_BYTE    = 4'b0001;
  localparam logic [3:0] MEM_BE_HALF_LO = 4'b0011;
  localparam logic [3:0] MEM_BE_HALF_HI = 4'b1100;
  localparam logic [3:0] MEM_BE_WORD    = 4'b1111;

  // True for the three load encodings; unknown codes are not loads
  function automatic logic op_is_load(input logic [3:0] op);
    logic r;
    case (op)
      MEM_LB, MEM_LH, MEM_LW: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: purely combinational lane handling for the load/store unit.
//   Request side  (op_i, addr_lo_i, st_data_i): op validity, load/store kind,
//                 misalignment, byte enables and lane-replicated store data.
//   Response side (ld_op_i, ld_addr_lo_i, rdata_i): selects the addressed
//                 byte/half/word from the bus word and sign-extends it.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic        valid_o,
  output logic        is_load_o,
  output logic        misalign_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [3:0]  ld_op_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Request decode: validity, misalignment, byte enables, store lanes
  always_comb begin
    valid_o    = 1'b0;
    is_load_o  = op_is_load(op_i);
    misalign_o = 1'b0;
    be_o       = 4'b0000;
    wdata_o    = 32'h0000_0000;
    case (op_i)
      MEM_LB: begin
        valid_o = 1'b1;
        be_o    = MEM_BE_WORD;
      end
      MEM_LH: begin
        valid_o    = 1'b1;
        misalign_o = addr_lo_i[0];
        be_o       = MEM_BE_WORD;
      end
      MEM_LW: begin
        valid_o    = 1'b1;
        misalign_o = |addr_lo_i;
        be_o       = MEM_BE_WORD;
      end
      MEM_SB: begin
        valid_o = 1'b1;
        be_o    = MEM_BE_BYTE << addr_lo_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      MEM_SH: begin
        valid_o    = 1'b1;
        misalign_o = addr_lo_i[0];
        be_o       = addr_lo_i[1] ? MEM_BE_HALF_HI : MEM_BE_HALF_LO;
        wdata_o    = {2{st_data_i[15:0]}};
      end
      MEM_SW: begin
        valid_o    = 1'b1;
        misalign_o = |addr_lo_i;
        be_o       = MEM_BE_WORD;
        wdata_o    = st_data_i;
      end
      default: valid_o = 1'b0;
    endcase
  end

  // Load extraction: pick the addressed lane, then sign-extend by size
  always_comb begin
    byte_s = rdata_i[{ld_addr_lo_i, 3'b000} +: 8];
    half_s = rdata_i[{ld_addr_lo_i[1], 4'b0000} +: 16];
    case (ld_op_i)
      MEM_LB:  ld_data_o = {{24{byte_s[7]}}, byte_s};
      MEM_LH:  ld_data_o = {{16{half_s[15]}}, half_s};
      MEM_LW:  ld_data_o = rdata_i;
      default: ld_data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit.
// Turns each EX-stage memory op into one word-aligned req/gnt + rvalid bus
// transaction, stalls the pipeline until it completes, then drives write-back.
//   clk_i/rst_i           clock, async active-high reset
//   mem_*_i, reg_*_i      access and write-back info from EX
//   stall_o               holds EX/MEM and everything upstream
//   reg_we/waddr/wdata_o  write-back to the register file
//   misalign_o/bus_err_o  one-cycle pulses for dropped / timed-out accesses
//   bus_*                 data bus request (req/gnt) and response (rvalid)
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int RESP_TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_we_i,
  input  logic                  reg_we_i,
  input  logic [4:0]            reg_waddr_i,
  input  logic [DATA_WIDTH-1:0] reg_wdata_i,
  output logic                  stall_o,
  output logic                  reg_we_o,
  output logic [4:0]            reg_waddr_o,
  output logic [DATA_WIDTH-1:0] reg_wdata_o,
  output logic                  misalign_o,
  output logic                  bus_err_o,
  output logic                  bus_req_o,
  input  logic                  bus_gnt_i,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic                  bus_we_o,
  output logic [3:0]            bus_be_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic                  bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

  localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

  bus_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:2] addr_q, addr_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [3:0]            op_q, op_d;
  logic [4:0]            waddr_q, waddr_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  op_valid_s, op_load_s, op_misalign_s;
  logic [3:0]            op_be_s;
  logic [DATA_WIDTH-1:0] op_wdata_s, ld_data_s;
  logic                  stall_s, reg_we_s, misalign_s, bus_err_s;
  logic [4:0]            reg_waddr_s;
  logic [DATA_WIDTH-1:0] reg_wdata_s;
  logic                  unused_s;

  // mem_we_i duplicates what mem_op_i already encodes
  assign unused_s = mem_we_i;

  mem_lane_align u_lane (
    .op_i         (mem_op_i),
    .addr_lo_i    (mem_addr_i[1:0]),
    .st_data_i    (mem_data_i),
    .valid_o      (op_valid_s),
    .is_load_o    (op_load_s),
    .misalign_o   (op_misalign_s),
    .be_o         (op_be_s),
    .wdata_o      (op_wdata_s),
    .ld_op_i      (op_q),
    .ld_addr_lo_i (addr_lo_q),
    .rdata_i      (bus_rdata_i),
    .ld_data_o    (ld_data_s)
  );

  // Next-state, capture and combinational write-back/stall decode
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    addr_lo_d   = addr_lo_q;
    op_d        = op_q;
    waddr_d     = waddr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    result_d    = result_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    stall_s     = 1'b0;
    reg_we_s    = 1'b0;
    reg_waddr_s = waddr_q;
    reg_wdata_s = '0;
    misalign_s  = 1'b0;
    bus_err_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        reg_we_s    = reg_we_i;
        reg_waddr_s = reg_waddr_i;
        reg_wdata_s = reg_wdata_i;
        if (op_valid_s && op_misalign_s) begin
          misalign_s = 1'b1;
          reg_we_s   = 1'b0;
        end else if (op_valid_s) begin
          stall_s   = 1'b1;
          reg_we_s  = 1'b0;
          addr_d    = mem_addr_i[ADDR_WIDTH-1:2];
          addr_lo_d = mem_addr_i[1:0];
          op_d      = mem_op_i;
          waddr_d   = reg_waddr_i;
          be_d      = op_be_s;
          wdata_d   = op_wdata_s;
          result_d  = '0;
          bus_req_d = 1'b1;
          bus_we_d  = ~op_load_s;
          err_d     = 1'b0;
          cnt_d     = '0;
          state_d   = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        stall_s = 1'b1;
        if (bus_gnt_i) begin
          bus_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = op_is_load(op_q) ? ST_RESP : ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_s = 1'b1;
          err_d     = 1'b1;
          bus_req_d = 1'b0;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        stall_s = 1'b1;
        if (bus_rvalid_i) begin
          result_d = ld_data_s;
          state_d  = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_s = 1'b1;
          err_d     = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        reg_we_s    = op_is_load(op_q) & ~err_q;
        reg_wdata_s = result_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and capture registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      addr_lo_q <= 2'b00;
      op_q      <= 4'b0000;
      waddr_q   <= 5'b00000;
      be_q      <= 4'b0000;
      wdata_q   <= '0;
      result_q  <= '0;
      bus_req_q <= 1'b0;
      bus_we_q  <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      addr_lo_q <= addr_lo_d;
      op_q      <= op_d;
      waddr_q   <= waddr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      result_q  <= result_d;
      bus_req_q <= bus_req_d;
      bus_we_q  <= bus_we_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Pipeline-facing outputs are masked while reset is held so a pending op
  // on the inputs cannot stall or write back during reset.
  assign stall_o     = stall_s & ~rst_i;
  assign reg_we_o    = reg_we_s & ~rst_i;
  assign misalign_o  = misalign_s & ~rst_i;
  assign bus_err_o   = bus_err_s & ~rst_i;
  assign reg_waddr_o = reg_waddr_s;
  assign reg_wdata_o = reg_wdata_s;
  assign bus_req_o   = bus_req_q;
  assign bus_addr_o  = {addr_q, 2'b00};
  assign bus_we_o    = bus_we_q;
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, random
// accesses against a byte-array memory model, and reset corner sequences.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int TO = 16;

  logic clk_i = 1'b0;
  logic rst_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i, mem_data_i, reg_wdata_i, bus_rdata_i;
  logic        mem_we_i, reg_we_i, bus_gnt_i, bus_rvalid_i;
  logic [4:0]  reg_waddr_i;
  logic        stall_o, reg_we_o, misalign_o, bus_err_o, bus_req_o, bus_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESP_TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_we_i(mem_we_i), .reg_we_i(reg_we_i),
    .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i), .stall_o(stall_o),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .bus_req_o(bus_req_o),
    .bus_gnt_i(bus_gnt_i), .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int stall; int req; logic [31:0] baddr; logic [3:0] be; logic [31:0] bwdata; logic bwe;
    logic rwe; logic [4:0] rwaddr; logic [31:0] rwdata; int mis; int err; int err_cyc;
  } obs_t;

  typedef struct {
    logic [3:0] op; logic [31:0] addr; logic [31:0] data; logic [4:0] wa; logic rwe;
    logic [31:0] rwd; int gd; int rd; bit spur; logic [31:0] pre; obs_t e;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] mem_b [0:63];
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int op_size(input logic [3:0] op);
    case (op)
      MEM_LB, MEM_SB: return 1;
      MEM_LH, MEM_SH: return 2;
      MEM_LW, MEM_SW: return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    int b;
    b = int'(addr[5:2]) * 4;
    return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
  endfunction

  // Reference: expected observation from the access rules; applies stores to mem_b
  task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] wa, input logic rwe, input logic [31:0] rwd,
                       input int gd, input int rd, output obs_t e);
    int sz, off, base;
    bit ld;
    longint v;
    e = '{default: 0};
    sz = op_size(op);
    ld = (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW);
    if (sz == 0) begin
      e.rwe = rwe; e.rwaddr = wa; e.rwdata = rwd;
      return;
    end
    off = int'(addr[1:0]);
    if (off % sz != 0) begin
      e.mis = 1;
      return;
    end
    e.req = 1; e.baddr = {addr[31:2], 2'b00}; e.bwe = !ld;
    for (int k = 0; k < 4; k++) begin
      if (ld) e.be[k] = 1'b1;
      else if (k >= off && k < off + sz) e.be[k] = 1'b1;
      if (!ld) e.bwdata[8*k +: 8] = data[8*(k % sz) +: 8];
    end
    if (gd >= TO) begin
      e.err = 1; e.err_cyc = TO; e.stall = 1 + TO;
    end else if (ld && rd > TO) begin
      e.err = 1; e.err_cyc = gd + 1 + TO; e.stall = gd + 2 + TO;
    end else begin
      e.stall = gd + 2 + (ld ? rd : 0);
      base = int'(addr[5:0]);
      if (ld) begin
        v = 0;
        for (int k = 0; k < sz; k++) v = v | (longint'(mem_b[(base + k) & 63]) << (8 * k));
        if (sz < 4 && v[8*sz-1]) v = v - (longint'(1) << (8 * sz));
        e.rwe = 1'b1; e.rwaddr = wa; e.rwdata = v[31:0];
      end else begin
        for (int k = 0; k < sz; k++) mem_b[(base + k) & 63] = data[8*k +: 8];
      end
    end
  endtask

  // Drive one access from IDLE (called at posedge+1), act as the bus, observe
  task automatic run_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input logic [4:0] wa, input logic rwe, input logic [31:0] rwd,
                            input int gd, input int rd, input bit spur, output obs_t o);
    int cyc, gcyc, req_cnt;
    bit granted, fin;
    o = '{default: 0};
    mem_op_i = op; mem_addr_i = addr; mem_data_i = data; reg_waddr_i = wa;
    reg_we_i = rwe; reg_wdata_i = rwd;
    mem_we_i = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    cyc = 0; gcyc = 0; req_cnt = 0; granted = 0; fin = 0;
    while (!fin && cyc < 64) begin
      bus_gnt_i = bus_req_o && (req_cnt == gd);
      bus_rvalid_i = 1'b0;
      bus_rdata_i = $urandom;
      if (granted && cyc == gcyc + rd) begin
        bus_rvalid_i = 1'b1;
        bus_rdata_i = mem_word(addr);
      end else if (bus_gnt_i && spur) begin
        bus_rvalid_i = 1'b1;
      end
      @(negedge clk_i);
      if (stall_o) o.stall++;
      if (bus_req_o) begin
        o.req = 1; o.baddr = bus_addr_o; o.be = bus_be_o; o.bwdata = bus_wdata_o; o.bwe = bus_we_o;
      end
      if (misalign_o) o.mis++;
      if (bus_err_o) begin o.err++; o.err_cyc = cyc; end
      if (!stall_o) begin
        fin = 1; o.rwe = reg_we_o; o.rwaddr = reg_waddr_o; o.rwdata = reg_wdata_o;
      end
      if (bus_gnt_i) begin granted = 1; gcyc = cyc; end
      if (bus_req_o) req_cnt++;
      @(posedge clk_i); #1;
      cyc++;
    end
    if (!fin) begin
      n_chk++; n_err++;
      $display("FAIL access_timeout: got no completion within %0d cycles, required completion", cyc);
    end
    mem_op_i = MEM_NOP; reg_we_i = 1'b0; mem_we_i = 1'b0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
  endtask

  task automatic compare(input string tag, input obs_t e, input obs_t o);
    chk({tag, ".stall"}, o.stall, e.stall);
    chk({tag, ".req"}, o.req, e.req);
    if (e.req != 0) begin
      chk({tag, ".baddr"}, o.baddr, e.baddr);
      chk({tag, ".be"}, {28'h0, o.be}, {28'h0, e.be});
      chk({tag, ".bwe"}, {31'h0, o.bwe}, {31'h0, e.bwe});
      if (e.bwe) chk({tag, ".bwdata"}, o.bwdata, e.bwdata);
    end
    chk({tag, ".rwe"}, {31'h0, o.rwe}, {31'h0, e.rwe});
    if (e.rwe) begin
      chk({tag, ".rwdata"}, o.rwdata, e.rwdata);
      chk({tag, ".rwaddr"}, {27'h0, o.rwaddr}, {27'h0, e.rwaddr});
    end
    chk({tag, ".mis"}, o.mis, e.mis);
    chk({tag, ".err"}, o.err, e.err);
    if (e.err != 0) chk({tag, ".err_cyc"}, o.err_cyc, e.err_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e, o;
    logic [3:0] op;
    logic [31:0] addr;
    int gd, rd, r, b;

    //                op      addr         data          wa    rwe   rwd           gd  rd spur pre
    //   expected: stall req baddr be bwdata bwe | rwe rwaddr rwdata | mis err err_cyc
    tbl[0]  = '{MEM_SB, 32'h103, 32'h000000A5, 5'd1, 1'b0, 32'h0, 0, 1, 0, 32'h0,
                '{2, 1, 32'h100, 4'b1000, 32'hA5A5A5A5, 1'b1, 1'b0, 5'd0, 32'h0, 0, 0, 0}};
    tbl[1]  = '{MEM_LB, 32'h202, 32'h0, 5'd3, 1'b1, 32'h0, 0, 2, 1, 32'h12F45678,
                '{4, 1, 32'h200, 4'b1111, 32'h0, 1'b0, 1'b1, 5'd3, 32'hFFFFFFF4, 0, 0, 0}};
    tbl[2]  = '{MEM_LH, 32'h201, 32'h0, 5'd4, 1'b1, 32'h0, 0, 1, 0, 32'h0,
                '{0, 0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1, 0, 0}};
    tbl[3]  = '{MEM_LW, 32'h301, 32'h0, 5'd4, 1'b1, 32'h0, 0, 1, 0, 32'h0,
                '{0, 0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1, 0, 0}};
    tbl[4]  = '{MEM_NOP, 32'h0, 32'h0, 5'd9, 1'b1, 32'hDEADBEEF, 0, 1, 0, 32'h0,
                '{0, 0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1, 5'd9, 32'hDEADBEEF, 0, 0, 0}};
    tbl[5]  = '{MEM_SW, 32'h40, 32'h13579BDF, 5'd2, 1'b0, 32'h0, 99, 1, 0, 32'h0,
                '{17, 1, 32'h40, 4'b1111, 32'h13579BDF, 1'b1, 1'b0, 5'd0, 32'h0, 0, 1, 16}};
    tbl[6]  = '{MEM_LH, 32'h206, 32'h0, 5'd5, 1'b1, 32'h0, 1, 1, 0, 32'h80017FFF,
                '{4, 1, 32'h204, 4'b1111, 32'h0, 1'b0, 1'b1, 5'd5, 32'hFFFF8001, 0, 0, 0}};
    tbl[7]  = '{MEM_SH, 32'h302, 32'h1234ABCD, 5'd6, 1'b0, 32'h0, 0, 1, 0, 32'h0,
                '{2, 1, 32'h300, 4'b1100, 32'hABCDABCD, 1'b1, 1'b0, 5'd0, 32'h0, 0, 0, 0}};
    tbl[8]  = '{MEM_LW, 32'h10, 32'h0, 5'd8, 1'b1, 32'h0, 1, 99, 0, 32'h0,
                '{19, 1, 32'h10, 4'b1111, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 0, 1, 18}};
    tbl[9]  = '{MEM_LB, 32'h3, 32'h0, 5'd10, 1'b1, 32'h0, 2, 1, 1, 32'h7F000000,
                '{5, 1, 32'h0, 4'b1111, 32'h0, 1'b0, 1'b1, 5'd10, 32'h0000007F, 0, 0, 0}};
    tbl[10] = '{4'hF, 32'h44, 32'h0, 5'd17, 1'b1, 32'h0BADF00D, 0, 1, 0, 32'h0,
                '{0, 0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1, 5'd17, 32'h0BADF00D, 0, 0, 0}};
    tbl[11] = '{MEM_SB, 32'h101, 32'h000001FF, 5'd11, 1'b0, 32'h0, 1, 1, 0, 32'h0,
                '{3, 1, 32'h100, 4'b0010, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd0, 32'h0, 0, 0, 0}};

    // Reset with a load pending on the inputs
    rst_i = 1'b1; mem_op_i = MEM_LW; mem_addr_i = 32'h0; mem_data_i = 32'h0; mem_we_i = 1'b0;
    reg_we_i = 1'b1; reg_waddr_i = 5'd0; reg_wdata_i = 32'h0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
    repeat (2) @(negedge clk_i);
    chk("reset.stall", {31'h0, stall_o}, 32'h0);
    chk("reset.bus_req", {31'h0, bus_req_o}, 32'h0);
    chk("reset.reg_we", {31'h0, reg_we_o}, 32'h0);
    chk("reset.misalign", {31'h0, misalign_o}, 32'h0);
    chk("reset.bus_err", {31'h0, bus_err_o}, 32'h0);
    mem_op_i = MEM_NOP; reg_we_i = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      b = int'(tbl[i].addr[5:2]) * 4;
      for (int k = 0; k < 4; k++) mem_b[b + k] = tbl[i].pre[8*k +: 8];
      run_access(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].wa, tbl[i].rwe, tbl[i].rwd,
                 tbl[i].gd, tbl[i].rd, tbl[i].spur, o);
      compare($sformatf("vec%0d", i), tbl[i].e, o);
    end

    // Randomized accesses against the memory model
    for (int i = 0; i < 64; i++) mem_b[i] = 8'($urandom);
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      op = (r <= 6) ? 4'(r) : 4'($urandom_range(7, 15));
      addr = {24'h0, 8'($urandom)};
      gd = $urandom_range(0, 3);
      rd = $urandom_range(1, 3);
      if ($urandom_range(0, 24) == 0) gd = 20;
      begin
        logic [31:0] d, rwd;
        logic [4:0] wa;
        logic rwe;
        d = $urandom; rwd = $urandom; wa = 5'($urandom); rwe = 1'($urandom);
        model(op, addr, d, wa, rwe, rwd, gd, rd, e);
        run_access(op, addr, d, wa, rwe, rwd, gd, rd, 1'($urandom), o);
        compare($sformatf("rnd%0d", i), e, o);
      end
    end

    // Reset during RESP of an LW, then a late rvalid, then a clean LW
    mem_op_i = MEM_LW; mem_addr_i = 32'h20; reg_waddr_i = 5'd7; reg_we_i = 1'b1;
    @(negedge clk_i); chk("rst_resp.idle_stall", {31'h0, stall_o}, 32'h1);
    @(posedge clk_i); #1 bus_gnt_i = 1'b1;
    @(negedge clk_i); chk("rst_resp.req", {31'h0, bus_req_o}, 32'h1);
    @(posedge clk_i); #1 bus_gnt_i = 1'b0;
    @(negedge clk_i); chk("rst_resp.resp_stall", {31'h0, stall_o}, 32'h1);
    #1 rst_i = 1'b1; #1;
    chk("rst_resp.stall", {31'h0, stall_o}, 32'h0);
    chk("rst_resp.bus_req", {31'h0, bus_req_o}, 32'h0);
    chk("rst_resp.reg_we", {31'h0, reg_we_o}, 32'h0);
    @(posedge clk_i); #1 mem_op_i = MEM_NOP; reg_we_i = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
    @(negedge clk_i);
    chk("late_rvalid.reg_we", {31'h0, reg_we_o}, 32'h0);
    chk("late_rvalid.stall", {31'h0, stall_o}, 32'h0);
    @(posedge clk_i); #1 bus_rvalid_i = 1'b0;
    model(MEM_LW, 32'h20, 32'h0, 5'd7, 1'b1, 32'h0, 0, 1, e);
    run_access(MEM_LW, 32'h20, 32'h0, 5'd7, 1'b1, 32'h0, 0, 1, 1'b0, o);
    compare("after_rst_lw", e, o);

    // Reset while a store request is waiting for grant drops bus_req at once
    mem_op_i = MEM_SW; mem_addr_i = 32'h24; mem_data_i = 32'h55AA55AA;
    @(posedge clk_i); #1;
    @(negedge clk_i); chk("rst_req.req", {31'h0, bus_req_o}, 32'h1);
    #1 rst_i = 1'b1; #1;
    chk("rst_req.bus_req", {31'h0, bus_req_o}, 32'h0);
    @(posedge clk_i); #1 mem_op_i = MEM_NOP;
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_req.idle_req", {31'h0, bus_req_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the execute stage's load/store outputs (mem_op, mem_addr, mem_data, mem_we, reg_we, reg_wdata).
- Converts each access into a word-aligned request on the data bus, using a req/gnt request phase and an rvalid response phase.
- Generates byte enables and lane-replicated store data, and extracts and sign-extends load data for LB/LH/LW.
- Stalls the pipeline until the access completes, then drives write-back.

Parameters:
- DATA_WIDTH, 32, data path width; only 32 is supported.
- ADDR_WIDTH, 32, byte address width.
- RESP_TIMEOUT, 16, maximum cycles to wait in REQ or RESP before aborting with bus_err_o.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- mem_op_i  in  4  MEM_NOP/LB/LH/LW/SB/SH/SW, encodings from defines.v; any other code is treated as MEM_NOP.
- mem_addr_i  in  ADDR_WIDTH  byte address.
- mem_data_i  in  DATA_WIDTH  store data, in the low bits.
- mem_we_i  in  1  1 for a store; informational only, decoding is done from mem_op_i.
- reg_we_i  in  1  write-back enable from EX.
- reg_waddr_i  in  5  destination register.
- reg_wdata_i  in  DATA_WIDTH  write-back data for non-memory ops.
- stall_o  out  1  hold the EX/MEM register and all upstream stages.
- reg_we_o  out  1  write-back enable.
- reg_waddr_o  out  5  write-back register.
- reg_wdata_o  out  DATA_WIDTH  write-back data.
- misalign_o  out  1  one-cycle pulse: misaligned access, dropped.
- bus_err_o  out  1  one-cycle pulse: bus timeout, access aborted.
- bus_req_o  out  1  request valid.
- bus_gnt_i  in  1  request accepted.
- bus_addr_o  out  ADDR_WIDTH  {addr[31:2],2'b00}.
- bus_we_o  out  1  write request.
- bus_be_o  out  4  byte enables.
- bus_wdata_o  out  DATA_WIDTH  lane-aligned store data.
- bus_rvalid_i  in  1  read data valid.
- bus_rdata_i  in  DATA_WIDTH  read word.

Behaviour:
- Reset: state goes to IDLE immediately. All registered outputs and internal registers are 0, and the timeout counter is 0. bus_req_o drops asynchronously. An aborted in-flight access is abandoned; the bus must tolerate a dropped request or a late rvalid. stall_o is 0 during reset.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE, mem_op_i = NOP:
  - reg_we_o/reg_waddr_o/reg_wdata_o = the *_i inputs, combinationally.
  - stall_o = 0; no state change.
- IDLE, valid op, misaligned (LH with addr[0]=1; LW/SW with addr[1:0]!=0; same rule for SH as LH):
  - misalign_o = 1 for this cycle, combinationally.
  - reg_we_o = 0, stall_o = 0; remain in IDLE; no bus activity.
- IDLE, valid aligned op:
  - stall_o = 1.
  - Capture addr[1:0], op, reg_waddr, be, and wdata into registers.
  - Next state is REQ.
- REQ:
  - bus_req_o = 1, driven from registers; stall_o = 1.
  - On bus_gnt_i: a store goes to DONE, a load goes to RESP.
  - Address, be, wdata, and we must be held stable until gnt.
- RESP:
  - stall_o = 1.
  - On bus_rvalid_i: extract, sign-extend, and register the result; go to DONE.
  - rvalid arriving in the same cycle as gnt is ignored; the earliest accepted rvalid is the cycle after gnt.
- DONE:
  - stall_o = 0; misalign_o and bus_err_o stay 0.
  - reg_we_o = 1 for loads, 0 for stores; reg_wdata_o/reg_waddr_o come from registers.
  - Next state is IDLE. Upstream advances on this edge.
- Timeout:
  - The counter clears on entry to REQ and on the REQ->RESP transition, and increments in REQ/RESP.
  - When it reaches RESP_TIMEOUT-1 with no gnt/rvalid: bus_err_o pulses that cycle, the next state is DONE, and reg_we_o = 0 in DONE.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{d[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{d[15:0]}}.
  - SW: be = 4'b1111; wdata = d.
- Load requests: be = 4'b1111, bus_we_o = 0.
- Load extraction:
  - LB: byte = rdata[8*addr[1:0] +: 8], sign-extended to 32 bits.
  - LH: half = rdata[16*addr[1] +: 16], sign-extended.
  - LW: the full word.
- Latency with immediate gnt/rvalid: stores take 3 cycles (IDLE, REQ, DONE); loads take 4 cycles (IDLE, REQ, RESP, DONE). Minimum throughput is 1 access per 3 cycles.
- Inputs change only when stall_o = 0. The next op is first sampled in IDLE, the cycle after DONE.

Decomposition:
- defines.v already holds the MEM_* op codes and width macros. Add the bus FSM state encoding and MEM_BE_* constants there.
- One combinational sub-module, mem_lane_align, holds the be/wdata generation, the misalignment check, and the load extraction/sign extension. Test it standalone.

Test Plan:
- SB, addr=0x103, data=0x000000A5, gnt immediate -> bus_addr_o=0x100, be=4'b1000, wdata=0xA5A5A5A5, bus_we_o=1. Stall lasts 2 cycles; reg_we_o=0 in DONE.
- LB, addr=0x202, rdata=0x12F45678, rvalid 2 cycles after gnt -> reg_wdata_o=0xFFFFFFF4, reg_we_o=1 in DONE. stall_o is high for exactly 4 cycles (IDLE, REQ, 2 cycles in RESP).
- LH at addr=0x201 -> misalign_o one pulse, no bus_req_o, stall_o=0, reg_we_o=0.
- LW at addr=0x301 -> same as the LH case. Also check that mem_op_i=NOP with reg_we_i=1, reg_wdata_i=0xDEADBEEF passes straight through in the same cycle.
- SW with bus_gnt_i held 0 and RESP_TIMEOUT=16 -> bus_err_o pulses on the 16th REQ cycle, then DONE with reg_we_o=0, then IDLE.
- rst_i asserted during RESP of an LW -> bus_req_o, stall_o, and reg_we_o are 0 immediately. A late rvalid after reset release is ignored, and the next LW completes normally.
